// File: rtl/adc_reader.sv
// rtl/adc_reader.sv - SPI reader for a 10-bit two-channel successive-approximation ADC
//
// Purpose:
//   Periodically runs a 15-clock SPI mode-0 frame against the ADC. The frame
//   sends a start/single-ended/channel/MSB-first command and captures a null
//   bit plus a 10-bit result. A frame is accepted only when its null bit is 0.
//   An accepted frame updates `actual` and pulses `adcready`. A rejected frame
//   pulses `frame_err` and leaves `actual` unchanged.
//
// Parameters:
//   CLK_DIV        clk cycles per adc_sclk half-period (>= 2)
//   SAMPLE_PERIOD  clk cycles between frame starts (> 32*CLK_DIV)
//   CHANNEL        ADC channel select, 0 or 1
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   enable     in   high permits new conversions
//   adc_miso   in   serial data from the ADC
//   adc_sclk   out  serial clock, idle low
//   adc_cs_n   out  chip select, active-low
//   adc_mosi   out  command data to the ADC
//   actual     out  last converted (or averaged) value
//   adcready   out  one-clk pulse: actual has just updated
//   frame_err  out  one-clk pulse: frame rejected because its null bit was 1
//
// Build option:
//   ADC_AVERAGE_EN  when defined, actual is the truncated mean of 4 accepted
//                   frames and adcready pulses once per 4 accepted frames.

module adc_reader #(
  parameter int CLK_DIV       = 8,
  parameter int SAMPLE_PERIOD = 10000,
  parameter int CHANNEL       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       adc_miso,
  output logic       adc_sclk,
  output logic       adc_cs_n,
  output logic       adc_mosi,
  output logic [9:0] actual,
  output logic       adcready,
  output logic       frame_err
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

  // Command bits in transmit order, bit 0 first: start, single-ended,
  // channel select, MSB-first.
  localparam logic [3:0] CMD_WORD  = {1'b1, (CHANNEL != 0), 1'b1, 1'b1};

  // adc_sclk falls 15 times per frame; the 15th fall opens the last low phase.
  localparam logic [3:0] LAST_FALL = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [TMR_W-1:0] timer;
  logic [DIV_W-1:0] div_cnt;
  logic             phase_low;
  logic [3:0]       fall_cnt;

  // Bit 10 holds the null bit, bits 9:0 hold D9..D0 once all 15 periods
  // have been sampled; the older command-phase samples have shifted out.
  logic [10:0]      shreg;

  logic             div_tick;
  logic             sclk_rise;
  logic             sclk_fall;
  logic             frame_done;

  assign div_tick   = (div_cnt == DIV_LAST);

  // Edge that drives adc_sclk 0->1: the end of SETUP, or the end of every
  // low phase except the final one (which leads into HOLD instead).
  assign sclk_rise  = div_tick &&
                      ((state == SETUP) ||
                       ((state == SHIFT) && phase_low && (fall_cnt != LAST_FALL)));

  assign sclk_fall  = div_tick && (state == SHIFT) && !phase_low;
  assign frame_done = div_tick && (state == HOLD);

  // Sample timer: free-runs while enabled, parked at 0 otherwise, so a frame
  // starts on the first enabled edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!enable) begin
      timer <= '0;
    end else if (timer == TMR_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic. A timer tick seen outside IDLE is simply dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (enable && (timer == '0)) state_nx = SETUP;
      SETUP: if (div_tick) state_nx = SHIFT;
      SHIFT: if (div_tick && phase_low && (fall_cnt == LAST_FALL)) state_nx = HOLD;
      HOLD:  if (div_tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state only.
  always_comb begin
    adc_cs_n = 1'b1;
    adc_sclk = 1'b0;
    adc_mosi = 1'b0;
    case (state)
      SETUP, SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = (state == SHIFT) && !phase_low;
        // fall_cnt advances on the sclk falling edge, so mosi changes there.
        if (fall_cnt < 4'd4) begin
          adc_mosi = CMD_WORD[fall_cnt[1:0]];
        end
      end
      default: begin
        adc_cs_n = 1'b1;
      end
    endcase
  end

  // Bit-timing counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      phase_low <= 1'b0;
      fall_cnt  <= '0;
    end else begin
      if ((state == IDLE) || div_tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state != SHIFT) begin
        phase_low <= 1'b0;
      end else if (div_tick) begin
        phase_low <= ~phase_low;
      end

      if (state == IDLE) begin
        fall_cnt <= '0;
      end else if (sclk_fall) begin
        fall_cnt <= fall_cnt + 1'b1;
      end
    end
  end

`ifdef ADC_AVERAGE_EN
  logic [11:0] acc;
  logic [1:0]  avg_cnt;
  logic [11:0] acc_sum;

  // Four 10-bit samples sum to at most 4092, so 12 bits never overflow.
  assign acc_sum = acc + {2'b00, shreg[9:0]};
`endif

  // Capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      actual    <= '0;
      adcready  <= 1'b0;
      frame_err <= 1'b0;
`ifdef ADC_AVERAGE_EN
      acc       <= '0;
      avg_cnt   <= '0;
`endif
    end else begin
      adcready  <= 1'b0;
      frame_err <= 1'b0;

      if (sclk_rise) begin
        shreg <= {shreg[9:0], adc_miso};
      end

      if (frame_done) begin
        if (shreg[10]) begin
          frame_err <= 1'b1;
        end else begin
`ifdef ADC_AVERAGE_EN
          if (avg_cnt == 2'd3) begin
            actual   <= acc_sum[11:2];
            acc      <= '0;
            avg_cnt  <= '0;
            adcready <= 1'b1;
          end else begin
            acc     <= acc_sum;
            avg_cnt <= avg_cnt + 1'b1;
          end
`else
          actual   <= shreg[9:0];
          adcready <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_reader.sv
// tb/tb_adc_reader.sv - self-checking bench for adc_reader with a behavioural ADC and scoreboard
module tb_adc_reader;

  localparam int CD       = 2;
  localparam int SP       = 100;
  localparam int LATENCY  = 32 * CD;

  // Command bits as the ADC sees them, bit 0 first: start, single-ended,
  // channel 0, MSB-first.
  localparam logic [3:0] EXP_CMD_CH0 = 4'b1011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       adc_miso = 1'b0;
  logic       adc_sclk;
  logic       adc_cs_n;
  logic       adc_mosi;
  logic [9:0] actual;
  logic       adcready;
  logic       frame_err;

  logic       ch1_miso = 1'b0;
  logic       ch1_sclk;
  logic       ch1_cs_n;
  logic       ch1_mosi;
  logic [9:0] ch1_actual;
  logic       ch1_ready;
  logic       ch1_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  adc_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CHANNEL(0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .adc_miso  (adc_miso),
    .adc_sclk  (adc_sclk),
    .adc_cs_n  (adc_cs_n),
    .adc_mosi  (adc_mosi),
    .actual    (actual),
    .adcready  (adcready),
    .frame_err (frame_err)
  );

  adc_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CHANNEL(1)) u_dut_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .adc_miso  (ch1_miso),
    .adc_sclk  (ch1_sclk),
    .adc_cs_n  (ch1_cs_n),
    .adc_mosi  (ch1_mosi),
    .actual    (ch1_actual),
    .adcready  (ch1_ready),
    .frame_err (ch1_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    if (obs != exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit the ADC presents for sclk period k (1..15).
  function automatic logic miso_bit(input int k, input logic [9:0] d, input logic n);
    if (k == 5) return n;
    if (k >= 6 && k <= 15) return d[15-k];
    return 1'b0;
  endfunction

  // ---------------- ADC model + scoreboard for the CHANNEL=0 instance ----------------
  logic [10:0] forced_q[$];   // {null, data} for upcoming frames
  logic [10:0] pick;
  int          ncyc = 0;
  bit          pending = 0;
  int          due = 0;
  logic [9:0]  cur_data = '0;
  logic        cur_null = 1'b0;
  int          rises = 0;
  int          falls = 0;
  bit          aborted = 1;
  logic [3:0]  cmd_seen = '0;
  logic [9:0]  model_actual = '0;
  int          acc = 0;
  int          nvalid = 0;
  int          frames_done = 0;
  int          cs_falls = 0;
  int          ready_cnt = 0;
  int          err_cnt = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [9:0]  last_actual = '0;
  bit          exp_rdy;
  bit          exp_err;

  always @(negedge clk) begin
    ncyc++;
    exp_rdy = 0;
    exp_err = 0;
    if (pending && ncyc == due) begin
      pending = 0;
      frames_done++;
      if (cur_null) begin
        exp_err = 1;
      end else begin
`ifdef ADC_AVERAGE_EN
        acc += int'(cur_data);
        nvalid++;
        if (nvalid == 4) begin
          exp_rdy      = 1;
          model_actual = 10'(acc / 4);
          acc          = 0;
          nvalid       = 0;
        end
`else
        exp_rdy      = 1;
        model_actual = cur_data;
`endif
      end
    end
    if (adcready || exp_rdy) check("adcready", int'(adcready), int'(exp_rdy));
    if (frame_err || exp_err) check("frame_err", int'(frame_err), int'(exp_err));
    if (adcready || exp_rdy || actual != last_actual)
      check("actual", int'(actual), int'(model_actual));
    if (adcready) ready_cnt++;
    if (frame_err) err_cnt++;
    last_actual = actual;

    if (!adc_cs_n && prev_cs) begin
      cs_falls++;
      check("frame_overlap", int'(pending), 0);
      if (forced_q.size() > 0) begin
        pick = forced_q.pop_front();
      end else begin
        pick = {($urandom_range(0, 3) == 0), 10'($urandom_range(0, 1023))};
      end
      cur_null = pick[10];
      cur_data = pick[9:0];
      pending  = 1;
      due      = ncyc + LATENCY;
      rises    = 0;
      falls    = 0;
      aborted  = 0;
      cmd_seen = '0;
      adc_miso = miso_bit(1, cur_data, cur_null);
    end else if (!adc_cs_n) begin
      if (adc_sclk && !prev_sclk) begin
        rises++;
        if (rises <= 4) cmd_seen[rises-1] = adc_mosi;
      end
      if (!adc_sclk && prev_sclk) begin
        falls++;
        adc_miso = miso_bit(falls + 1, cur_data, cur_null);
      end
    end
    if (adc_cs_n && !prev_cs && !aborted) begin
      check("sclk_periods", rises, 15);
      check("cmd_bits", int'(cmd_seen), int'(EXP_CMD_CH0));
    end
    // Reset seen now is applied at the coming edge.
    if (!rst_n) begin
      pending      = 0;
      aborted      = 1;
      model_actual = '0;
      acc          = 0;
      nvalid       = 0;
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  // ---------------- CHANNEL=1 instance: command bit and frame spacing ----------------
  int   ncyc1 = 0;
  int   last_fall1 = 0;
  bit   spacing_ok = 0;
  int   rises1 = 0;
  logic prev_cs1 = 1'b1;
  logic prev_sclk1 = 1'b0;

  always @(negedge clk) begin
    ncyc1++;
    if (!ch1_cs_n && prev_cs1) begin
      if (spacing_ok) check("ch1_cs_spacing", ncyc1 - last_fall1, SP);
      last_fall1 = ncyc1;
      spacing_ok = 1;
      rises1     = 0;
    end
    if (!ch1_cs_n && ch1_sclk && !prev_sclk1) begin
      rises1++;
      if (rises1 == 3) check("ch1_mosi_bit3", int'(ch1_mosi), 1);
    end
    if (!rst_n || !enable) spacing_ok = 0;
    prev_cs1   = ch1_cs_n;
    prev_sclk1 = ch1_sclk;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_frames(input int n);
    int target;
    bit ok;
    target = frames_done + n;
    ok = 0;
    for (int i = 0; i < n * SP * 2 + 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (frames_done >= target) ok = 1;
    end
    check("wait_frames", int'(ok), 1);
  endtask

  task automatic wait_cs_fall();
    int target;
    bit ok;
    target = cs_falls + 1;
    ok = 0;
    for (int i = 0; i < 2 * SP + 50 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (cs_falls >= target) ok = 1;
    end
    check("wait_cs_fall", int'(ok), 1);
  endtask

  // ---------------- stimulus ----------------
  int rb;
  int eb;
  int cs_low;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs_n", int'(adc_cs_n), 1);
    check("reset_sclk", int'(adc_sclk), 0);
    check("reset_mosi", int'(adc_mosi), 0);
    check("reset_actual", int'(actual), 0);
    check("reset_adcready", int'(adcready), 0);
    check("reset_frame_err", int'(frame_err), 0);

    // Known sample, first frame straight out of reset.
    forced_q.push_back({1'b0, 10'h2A5});
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("first_frame_cs_n", int'(adc_cs_n), 0);
    wait_frames(1);
`ifndef ADC_AVERAGE_EN
    check("known_sample_actual", int'(actual), 'h2A5);
`endif

    // Null bit set: rejected frame.
    forced_q.push_back({1'b1, 10'($urandom_range(0, 1023))});
    rb = ready_cnt;
    eb = err_cnt;
    wait_frames(1);
    check("null_frame_err_count", err_cnt - eb, 1);
    check("null_frame_no_ready", ready_cnt - rb, 0);
`ifndef ADC_AVERAGE_EN
    check("null_frame_actual_kept", int'(actual), 'h2A5);
`endif

    // Random frames under continuous enable.
    wait_frames(20);

    // enable drops mid-SHIFT: frame finishes, then no new frame.
    forced_q.push_back({1'b0, 10'($urandom_range(0, 1023))});
    wait_cs_fall();
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b0;
    rb = ready_cnt;
    wait_frames(1);
`ifndef ADC_AVERAGE_EN
    check("disable_frame_ready", ready_cnt - rb, 1);
`endif
    cs_low = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!adc_cs_n) cs_low++;
    end
    check("disabled_cs_low_cycles", cs_low, 0);

    // One-cycle reset mid-SHIFT, then an averaging run from a clean state.
    enable = 1'b1;
    wait_cs_fall();
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    forced_q.push_back({1'b0, 10'd100});
    forced_q.push_back({1'b0, 10'd101});
    forced_q.push_back({1'b0, 10'd102});
    forced_q.push_back({1'b0, 10'd104});
    rb = ready_cnt;
    @(posedge clk);
    #1;
    check("midreset_cs_n", int'(adc_cs_n), 1);
    check("midreset_sclk", int'(adc_sclk), 0);
    check("midreset_actual", int'(actual), 0);
    check("midreset_adcready", int'(adcready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_cs_n", int'(adc_cs_n), 0);
    wait_frames(4);
`ifdef ADC_AVERAGE_EN
    check("avg_ready_pulses", ready_cnt - rb, 1);
    check("avg_actual", int'(actual), 101);
`else
    check("seq_ready_pulses", ready_cnt - rb, 4);
    check("seq_actual", int'(actual), 104);
`endif

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adc_reader.md
ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: clk cycles per adc_sclk half-period; legal values are 2 or more.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 10000: clk cycles between frame starts; legal values are greater than 32*CLK_DIV.
REQ-003 SHALL have parameter CHANNEL, default 0: ADC channel select, 0 or 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: high permits new conversions.
REQ-007 SHALL have port adc_miso, input, 1 bit: serial data from the ADC.
REQ-008 SHALL have port adc_sclk, output, 1 bit: serial clock, idle low (SPI mode 0).
REQ-009 SHALL have port adc_cs_n, output, 1 bit: chip select, active-low.
REQ-010 SHALL have port adc_mosi, output, 1 bit: command data to the ADC.
REQ-011 SHALL have port actual, output, 10 bits: last converted value, registered.
REQ-012 SHALL have port adcready, output, 1 bit: one-clk pulse marking that actual has just updated.
REQ-013 SHALL have port frame_err, output, 1 bit: one-clk pulse marking a rejected frame.

Function
REQ-014 SHALL run a sample timer counting 0..SAMPLE_PERIOD-1 while enable=1; the timer holds at 0 while enable=0.
REQ-015 SHALL start a frame when the timer is 0, enable=1 and the FSM is in IDLE.
REQ-016 SHALL implement FSM states IDLE, SETUP, SHIFT and HOLD.
REQ-017 SETUP: adc_cs_n=0, adc_sclk=0, adc_mosi=start bit (1); duration CLK_DIV cycles.
REQ-018 SHIFT: exactly 15 adc_sclk periods, each CLK_DIV cycles high then CLK_DIV cycles low.
REQ-019 SHALL sample adc_miso on the clk edge where adc_sclk goes 0->1, and SHALL update adc_mosi on the edge where adc_sclk goes 1->0.
REQ-020 SHALL drive command bits on adc_mosi in this order: 1 (start), 1 (single-ended), CHANNEL, 1 (MSB-first); adc_mosi=0 thereafter.
REQ-021 SHALL treat SCLK period 5 as the null bit and periods 6..15 as D9..D0, MSB first.
REQ-022 HOLD: adc_cs_n=1, adc_sclk=0; duration CLK_DIV cycles, then return to IDLE.
REQ-023 SHALL, on leaving HOLD, load the shift register into actual and pulse adcready for exactly one cycle when the null bit was 0.
REQ-024 SHALL, on leaving HOLD with a null bit of 1, pulse frame_err for one cycle, keep actual unchanged, and not assert adcready.
REQ-025 Latency: SHALL assert adcready exactly 32*CLK_DIV clk cycles after the cycle in which adc_cs_n falls.
REQ-026 SHALL let a frame in progress complete normally if enable falls mid-frame; no new frame SHALL start while enable=0.
REQ-027 SHALL drop a timer tick that arrives while the FSM is not in IDLE; the FSM SHALL never re-enter SETUP before HOLD completes.

Reset
REQ-028 SHALL, on rst_n=0 at a clk edge, force: FSM=IDLE, timer=0, adc_cs_n=1, adc_sclk=0, adc_mosi=0, actual=0, adcready=0, frame_err=0, shift register=0.
REQ-029 SHALL abort any frame cleanly on rst_n low mid-frame, with no adcready pulse for the aborted frame.
REQ-030 SHALL start the first frame (adc_cs_n falls) on the first clk edge after rst_n=1 at which enable=1.

Configuration
REQ-031 With macro ADC_AVERAGE_EN defined: SHALL accumulate 4 valid frames in a 12-bit accumulator and pulse adcready once per 4 valid frames, with actual=accumulator>>2 (truncated).
REQ-032 With ADC_AVERAGE_EN defined: errored frames SHALL not be counted, and reset SHALL clear both the accumulator and the frame count.
REQ-033 Without ADC_AVERAGE_EN: every valid frame SHALL update actual and pulse adcready (REQ-023).

Verification (CLK_DIV=2, SAMPLE_PERIOD=100)
REQ-034 ADC model returns 10'h2A5 with null bit 0 -> actual=10'h2A5, single adcready pulse 64 cycles after adc_cs_n falls; adc_mosi bits 1,1,0,1.
REQ-035 Model drives null bit=1 -> frame_err pulses once, adcready stays 0, actual keeps its prior value.
REQ-036 enable dropped during SHIFT -> frame completes and adcready pulses; adc_cs_n then stays 1 for the next 300 cycles.
REQ-037 rst_n=0 for one cycle mid-SHIFT -> next cycle adc_cs_n=1, adc_sclk=0, actual=0, no adcready; new frame begins after release.
REQ-038 CHANNEL=1, continuous enable -> adc_mosi third bit=1; adc_cs_n falling edges spaced exactly 100 cycles apart.
REQ-039 ADC_AVERAGE_EN with samples 100, 101, 102, 104 -> exactly one adcready pulse, actual=101.
